// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the pipelined MIPS-funct ALU.
//   - funct opcode codes understood by alu_core
//   - bit positions inside the 5-bit flag vector {illegal, overflow, carry, negative, zero}
// Optional macro ALU_PIPE_SAT_EN: enables OP_ADDS/OP_SUBS in alu_core; without it they decode as illegal.
package alu_pkg;

  localparam logic [5:0] OP_SLL  = 6'b000000;
  localparam logic [5:0] OP_SRL  = 6'b000010;
  localparam logic [5:0] OP_SRA  = 6'b000011;
  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_ADDS = 6'b100001;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_SUBS = 6'b100011;
  localparam logic [5:0] OP_AND  = 6'b100100;
  localparam logic [5:0] OP_OR   = 6'b100101;
  localparam logic [5:0] OP_XOR  = 6'b100110;
  localparam logic [5:0] OP_NOR  = 6'b100111;
  localparam logic [5:0] OP_SLT  = 6'b101010;
  localparam logic [5:0] OP_SLTU = 6'b101011;

  localparam int FLAG_ZERO    = 0;
  localparam int FLAG_NEG     = 1;
  localparam int FLAG_CARRY   = 2;
  localparam int FLAG_OVF     = 3;
  localparam int FLAG_ILLEGAL = 4;
  localparam int FLAGS_W      = 5;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational N_BITS-wide ALU, result plus status flags.
// Ports:
//   i_a, i_b  : operands (low SHAMT_BITS of i_b are the shift amount)
//   i_op      : 6-bit funct opcode
//   o_res     : result (forced to 0 for an unknown opcode)
//   o_flags   : {illegal, overflow, carry, negative, zero}
// Macro ALU_PIPE_SAT_EN: adds signed saturating ADDS/SUBS; otherwise those codes are illegal.
module alu_core import alu_pkg::*; #(
  parameter int N_BITS     = 8,
  parameter int SHAMT_BITS = $clog2(N_BITS)
) (
  input  logic [N_BITS-1:0]  i_a,
  input  logic [N_BITS-1:0]  i_b,
  input  logic [5:0]         i_op,
  output logic [N_BITS-1:0]  o_res,
  output logic [FLAGS_W-1:0] o_flags
);

  localparam int MSB = N_BITS - 1;

  logic signed [N_BITS-1:0] a_s;
  logic signed [N_BITS-1:0] b_s;
  logic [N_BITS:0]          sum;
  logic [N_BITS:0]          diff;
  logic [SHAMT_BITS-1:0]    shamt;
  logic                     add_ovf;
  logic                     sub_ovf;
  logic [N_BITS-1:0]        res;
  logic                     carry;
  logic                     ovf;
  logic                     illegal;

  assign a_s   = i_a;
  assign b_s   = i_b;
  assign sum   = {1'b0, i_a} + {1'b0, i_b};
  // Top bit of the extended difference is the unsigned borrow (A < B).
  assign diff  = {1'b0, i_a} - {1'b0, i_b};
  assign shamt = i_b[SHAMT_BITS-1:0];

  assign add_ovf = (i_a[MSB] == i_b[MSB]) && (sum[MSB]  != i_a[MSB]);
  assign sub_ovf = (i_a[MSB] != i_b[MSB]) && (diff[MSB] != i_a[MSB]);

`ifdef ALU_PIPE_SAT_EN
  // On signed overflow the true result has the sign of A, so A's sign picks the rail.
  function automatic logic [N_BITS-1:0] sat_clamp(input logic neg_rail);
    return neg_rail ? {1'b1, {(N_BITS-1){1'b0}}} : {1'b0, {(N_BITS-1){1'b1}}};
  endfunction
`endif

  always_comb begin
    res     = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    illegal = 1'b0;
    case (i_op)
      OP_ADD:  begin res = sum[N_BITS-1:0];  carry = sum[N_BITS];  ovf = add_ovf; end
      OP_SUB:  begin res = diff[N_BITS-1:0]; carry = diff[N_BITS]; ovf = sub_ovf; end
      OP_AND:  res = i_a & i_b;
      OP_OR:   res = i_a | i_b;
      OP_XOR:  res = i_a ^ i_b;
      OP_NOR:  res = ~(i_a | i_b);
      OP_SLL:  res = i_a << shamt;
      OP_SRL:  res = i_a >> shamt;
      OP_SRA:  res = a_s >>> shamt;
      OP_SLT:  res = {{(N_BITS-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: res = {{(N_BITS-1){1'b0}}, (i_a < i_b)};
`ifdef ALU_PIPE_SAT_EN
      OP_ADDS: begin
        res = add_ovf ? sat_clamp(i_a[MSB]) : sum[N_BITS-1:0];
        ovf = add_ovf;
      end
      OP_SUBS: begin
        res = sub_ovf ? sat_clamp(i_a[MSB]) : diff[N_BITS-1:0];
        ovf = sub_ovf;
      end
`else
      OP_ADDS, OP_SUBS: illegal = 1'b1;
`endif
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    o_res                 = res;
    o_flags               = '0;
    o_flags[FLAG_ZERO]    = (res == '0);
    o_flags[FLAG_NEG]     = res[MSB];
    o_flags[FLAG_CARRY]   = carry;
    o_flags[FLAG_OVF]     = ovf;
    o_flags[FLAG_ILLEGAL] = illegal;
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: pipelined ALU with valid/ready on both sides.
// Ports:
//   i_clk, i_reset         : clock (rising edge), asynchronous active-high reset
//   i_valid / o_ready      : upstream handshake carrying i_dato_A, i_dato_B, i_operacion
//   o_valid / i_ready      : downstream handshake carrying o_alu, o_flags
//   o_flags                : {illegal, overflow, carry, negative, zero}
// Latency is PIPE_STAGES cycles with no backpressure; one op per cycle throughput.
// Macro ALU_PIPE_SAT_EN: enables saturating ADDS/SUBS in alu_core.
module alu_pipe import alu_pkg::*; #(
  parameter int N_BITS      = 8,
  parameter int PIPE_STAGES = 2,
  parameter int SHAMT_BITS  = $clog2(N_BITS)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [N_BITS-1:0]  i_dato_A,
  input  logic [N_BITS-1:0]  i_dato_B,
  input  logic [5:0]         i_operacion,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [N_BITS-1:0]  o_alu,
  output logic [FLAGS_W-1:0] o_flags
);

  localparam int LAST = PIPE_STAGES - 1;

  logic [N_BITS-1:0]  core_res;
  logic [FLAGS_W-1:0] core_flags;

  alu_core #(
    .N_BITS     (N_BITS),
    .SHAMT_BITS (SHAMT_BITS)
  ) u_core (
    .i_a     (i_dato_A),
    .i_b     (i_dato_B),
    .i_op    (i_operacion),
    .o_res   (core_res),
    .o_flags (core_flags)
  );

  logic [PIPE_STAGES-1:0]              vld_q, vld_d, load;
  logic [PIPE_STAGES-1:0][N_BITS-1:0]  res_q, res_d;
  logic [PIPE_STAGES-1:0][FLAGS_W-1:0] flg_q, flg_d;

  // A stage may load when empty or when the stage ahead of it moves on;
  // the chain ripples back from the output so a full pipe still streams
  // when the consumer takes a result in the same cycle.
  always_comb begin
    logic chain;
    chain      = ~vld_q[LAST] | i_ready;
    load       = '0;
    load[LAST] = chain;
    for (int k = LAST - 1; k >= 0; k--) begin
      chain   = ~vld_q[k] | chain;
      load[k] = chain;
    end
  end

  always_comb begin
    vld_d = vld_q;
    res_d = res_q;
    flg_d = flg_q;
    // Compute -> stage 0
    if (load[0]) begin
      vld_d[0] = i_valid;
      res_d[0] = core_res;
      flg_d[0] = core_flags;
    end
    // Stage k-1 -> stage k
    for (int k = 1; k < PIPE_STAGES; k++) begin
      if (load[k]) begin
        vld_d[k] = vld_q[k-1];
        res_d[k] = res_q[k-1];
        flg_d[k] = flg_q[k-1];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vld_q <= '0;
      res_q <= '0;
      flg_q <= '0;
    end else begin
      vld_q <= vld_d;
      res_q <= res_d;
      flg_q <= flg_d;
    end
  end

  assign o_ready = load[0];
  assign o_valid = vld_q[LAST];
  assign o_alu   = res_q[LAST];
  assign o_flags = flg_q[LAST];

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed scoreboard bench for alu_pipe (N_BITS=8, PIPE_STAGES=2).
// The driver pushes the hand-computed expectation for each accepted op; an
// independent monitor pops and compares whenever a result is consumed.
module tb_alu_pipe;

  localparam int PS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       o_ready;
  logic [7:0] a, b;
  logic [5:0] op;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_alu;
  logic [4:0] o_flags;

  always #5 clk = ~clk;

  alu_pipe #(.N_BITS(8), .PIPE_STAGES(PS)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_valid     (in_valid),
    .o_ready     (o_ready),
    .i_dato_A    (a),
    .i_dato_B    (b),
    .i_operacion (op),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_alu       (o_alu),
    .o_flags     (o_flags)
  );

  typedef struct {
    logic [7:0] alu;
    logic [4:0] flg;
    int         id;
    int         icyc;
    bit         chk_lat;
    bit         chk_gap;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         n_acc = 0;
  int         last_pop = -100;
  logic [7:0] held_alu;
  logic [4:0] held_flg;
  bit         held_v = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int id, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s #%0d: got %0h, expected %0h", nm, id, got, want);
    end
  endtask

  // Monitor: stability while stalled, and in-order scoreboard on consume.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held_v = 0;
    end else begin
      if (o_valid && !i_ready) begin
        if (held_v) begin
          check("stall_alu", 0, o_alu, held_alu);
          check("stall_flags", 0, o_flags, held_flg);
        end
        held_alu = o_alu;
        held_flg = o_flags;
        held_v   = 1;
      end else begin
        held_v = 0;
      end
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got alu=%0h flags=%0h, expected no output", o_alu, o_flags);
        end else begin
          e = sb.pop_front();
          check("alu", e.id, o_alu, e.alu);
          check("flags", e.id, o_flags, e.flg);
          if (e.chk_lat) check("latency", e.id, cyc - e.icyc, PS);
          if (e.chk_gap) check("gap", e.id, cyc - last_pop, 1);
          last_pop = cyc;
        end
      end
    end
  end

  // Present one op (inputs change #1 after posedge) and hold it until accepted.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [5:0] iop,
                       input logic [7:0] ea, input logic [4:0] ef, input int id,
                       input bit lat, input bit gap);
    bit   acc;
    int   c;
    exp_t e;
    in_valid = 1'b1;
    a        = ia;
    b        = ib;
    op       = iop;
    acc      = 0;
    c        = 0;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = o_ready;
      c   = cyc;
      @(posedge clk);
      #1;
    end
    if (acc) begin
      e.alu = ea; e.flg = ef; e.id = id; e.icyc = c; e.chk_lat = lat; e.chk_gap = gap;
      sb.push_back(e);
      n_acc++;
    end else begin
      total++;
      bad++;
      $display("FAIL accept_timeout #%0d: o_ready stayed 0, expected 1 within 50 cycles", id);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && sb.size() != 0; t++) @(negedge clk);
    check("drain", 0, sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int base;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; i_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 0, o_valid, 0);
    check("rst_alu", 0, o_alu, 0);
    check("rst_flags", 0, o_flags, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 0, o_ready, 1);
    @(posedge clk); #1;

    // ADD signed overflow, isolated: latency 2
    issue(8'h7F, 8'h01, 6'b100000, 8'h80, 5'h0A, 1, 1, 0);
    idle();
    drain();

    // Back-to-back directed vectors: latency 2 each and no gaps
    issue(8'h00, 8'h01, 6'b100010, 8'hFF, 5'h06, 10, 1, 0); // SUB borrow
    issue(8'h80, 8'h0A, 6'b000011, 8'hE0, 5'h02, 11, 1, 1); // SRA shamt 2
    issue(8'h80, 8'h0A, 6'b000010, 8'h20, 5'h00, 12, 1, 1); // SRL shamt 2
    issue(8'hFF, 8'h01, 6'b101010, 8'h01, 5'h00, 13, 1, 1); // SLT -1<1
    issue(8'hFF, 8'h01, 6'b101011, 8'h00, 5'h01, 14, 1, 1); // SLTU 255<1
    issue(8'h5A, 8'h33, 6'b111111, 8'h00, 5'h11, 15, 1, 1); // illegal
    issue(8'hF0, 8'h3C, 6'b100100, 8'h30, 5'h00, 16, 1, 1); // AND
    issue(8'hF0, 8'h0F, 6'b100101, 8'hFF, 5'h02, 17, 1, 1); // OR
    issue(8'hAA, 8'hAA, 6'b100110, 8'h00, 5'h01, 18, 1, 1); // XOR
    issue(8'h00, 8'h00, 6'b100111, 8'hFF, 5'h02, 19, 1, 1); // NOR
    issue(8'h01, 8'h0F, 6'b000000, 8'h80, 5'h02, 20, 1, 1); // SLL shamt 7
    issue(8'hFF, 8'h01, 6'b100000, 8'h00, 5'h05, 21, 1, 1); // ADD carry, zero
    issue(8'h80, 8'h01, 6'b100010, 8'h7F, 5'h08, 22, 1, 1); // SUB overflow
    issue(8'hF0, 8'hF9, 6'b000010, 8'h78, 5'h00, 23, 1, 1); // SRL, upper B ignored
    issue(8'h01, 8'hFF, 6'b101010, 8'h00, 5'h01, 24, 1, 1); // SLT 1<-1
    issue(8'h01, 8'hFF, 6'b101011, 8'h01, 5'h00, 25, 1, 1); // SLTU 1<255
    issue(8'h80, 8'h80, 6'b100000, 8'h00, 5'h0D, 26, 1, 1); // ADD carry+ovf+zero
    idle();
    drain();

    // Backpressure: 4 ADDs with i_ready low for 5 cycles
    i_ready = 1'b0;
    base    = n_acc;
    fork
      begin
        for (int i = 0; i < 4; i++)
          issue(8'(i), 8'(i + 1), 6'b100000, 8'(2 * i + 1), 5'h00, 30 + i, 0, i > 0);
        idle();
      end
      begin
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          if (j >= 2) begin
            check("bp_ready", j, o_ready, 0);
            check("bp_accepts", j, n_acc - base, 2);
          end
          @(posedge clk); #1;
        end
        i_ready = 1'b1;
      end
    join
    drain();

    // Reset with two ops in flight
    i_ready = 1'b0;
    issue(8'h01, 8'h01, 6'b100000, 8'h02, 5'h00, 40, 0, 0);
    issue(8'h02, 8'h02, 6'b100000, 8'h04, 5'h00, 41, 0, 0);
    idle();
    @(negedge clk);
    check("inflight_valid", 41, o_valid, 1);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check("async_rst_valid", 42, o_valid, 0);
    check("async_rst_alu", 42, o_alu, 0);
    check("async_rst_flags", 42, o_flags, 0);
    i_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 43, o_ready, 1);
    for (int j = 0; j < 6; j++) begin
      check("no_stale", 44 + j, o_valid, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    issue(8'h02, 8'h03, 6'b100000, 8'h05, 5'h00, 50, 1, 0);
    idle();
    drain();

    // Saturating ops, or their codes decoding as illegal
`ifdef ALU_PIPE_SAT_EN
    issue(8'h7F, 8'h01, 6'b100001, 8'h7F, 5'h08, 60, 1, 0); // ADDS clamp high
    issue(8'h80, 8'h01, 6'b100011, 8'h80, 5'h0A, 61, 1, 1); // SUBS clamp low
    issue(8'h10, 8'h20, 6'b100001, 8'h30, 5'h00, 62, 1, 1); // ADDS in range
`else
    issue(8'h7F, 8'h01, 6'b100001, 8'h00, 5'h11, 60, 1, 0);
    issue(8'h80, 8'h01, 6'b100011, 8'h00, 5'h11, 61, 1, 1);
`endif
    idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
